// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the LSU RAM initiator.
// Access sizes, FSM state codes and byte-lane masks.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B    = 2'd0,
    SZ_H    = 2'd1,
    SZ_W    = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t RMW_RD = 2'd1;
  localparam state_t RMW_WR = 2'd2;

  localparam logic [31:0] BYTE_MASK = 32'h0000_00ff;
  localparam logic [31:0] HALF_MASK = 32'h0000_ffff;
  localparam logic [31:0] WORD_MASK = 32'hffff_ffff;

endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: little-endian lane extract/extend for loads
// and lane merge for stores; purely combinational.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        zext,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] merged
);

  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] mask;

  assign sh      = {lane, 3'b000};
  assign shifted = word >> sh;

  always_comb begin
    ldata = '0;
    mask  = '0;
    case (size)
      SZ_B: begin
        ldata = {{24{~zext & shifted[7]}}, shifted[7:0]};
        mask  = BYTE_MASK << sh;
      end
      SZ_H: begin
        ldata = {{16{~zext & shifted[15]}}, shifted[15:0]};
        mask  = HALF_MASK << sh;
      end
      SZ_W: begin
        ldata = word;
        mask  = WORD_MASK;
      end
      default: ;
    endcase
  end

  // Word stores fall out of the same merge with a full mask.
  assign merged = (word & ~mask) | ((wdata << sh) & mask);

endmodule

// File: rtl/lsu_ram_initiator.sv
// lsu_ram_initiator: valid/ready load/store front end for a word RAM.
// Define LSU_RMW_EN to build read-modify-write sub-word stores.
module lsu_ram_initiator
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  state_t      state;
  logic        accept;
  logic        err;
  logic        word_wr;
  logic [31:0] lane_word;
  logic [31:0] lane_wdata;
  logic [1:0]  lane_sel;
  logic [1:0]  lane_size;
  logic [31:0] ldata;
  logic [31:0] merged;

  assign req_ready = (state == IDLE) && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    err = (req_addr[31:ADDR_WIDTH+2] != '0);
    case (req_size)
      SZ_H:    if (req_addr[0]) err = 1'b1;
      SZ_W:    if (req_addr[1:0] != 2'b00) err = 1'b1;
      SZ_RSVD: err = 1'b1;
      default: ;
    endcase
`ifndef LSU_RMW_EN
    if (req_we && (req_size != SZ_W)) err = 1'b1;
`endif
  end

  assign word_wr = accept && req_we && (req_size == SZ_W) && !err;

`ifdef LSU_RMW_EN
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [1:0]            lane_q;
  logic [1:0]            size_q;
  logic [15:0]           wdata_q;
  logic [31:0]           merge_q;
  logic                  in_wr;

  assign in_wr      = (state == RMW_WR);
  assign lane_word  = in_wr ? merge_q : mem_q;
  assign lane_sel   = in_wr ? lane_q : req_addr[1:0];
  assign lane_size  = in_wr ? size_q : req_size;
  assign lane_wdata = in_wr ? {16'h0000, wdata_q} : req_wdata;
  assign mem_addr   = (state == IDLE) ? req_addr[ADDR_WIDTH+1:2] : idx_q;
  assign mem_we     = (state == IDLE) ? word_wr : in_wr;
`else
  assign lane_word  = mem_q;
  assign lane_sel   = req_addr[1:0];
  assign lane_size  = req_size;
  assign lane_wdata = req_wdata;
  assign mem_addr   = req_addr[ADDR_WIDTH+1:2];
  assign mem_we     = word_wr;
`endif

  lsu_byte_lane u_lane (
    .word   (lane_word),
    .lane   (lane_sel),
    .size   (lane_size),
    .zext   (req_unsigned),
    .wdata  (lane_wdata),
    .ldata  (ldata),
    .merged (merged)
  );

  assign mem_data = merged;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
`ifdef LSU_RMW_EN
      idx_q     <= '0;
      lane_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      merge_q   <= '0;
`endif
    end else begin
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_tag   <= req_tag;
            rsp_err   <= err;
            rsp_rdata <= (err || req_we) ? '0 : ldata;
            rsp_valid <= 1'b1;
`ifdef LSU_RMW_EN
            // Sub-word store: response deferred until the merge is written.
            if (!err && req_we && (req_size != SZ_W)) begin
              rsp_valid <= 1'b0;
              idx_q     <= req_addr[ADDR_WIDTH+1:2];
              lane_q    <= req_addr[1:0];
              size_q    <= req_size;
              wdata_q   <= req_wdata[15:0];
              state     <= RMW_RD;
            end
`endif
          end
        end
`ifdef LSU_RMW_EN
        RMW_RD: begin
          merge_q <= mem_q;
          state   <= RMW_WR;
        end
        RMW_WR: begin
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ram_initiator.sv
// tb_lsu_ram_initiator: vector table, corner sequences and random
// traffic checked against a word-array model of the RAM.
module tb_lsu_ram_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic [31:0] mem_data;
  logic [6:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_q;

  logic [31:0] ram    [128];
  logic [31:0] shadow [128];
  int          we_cnt = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  lsu_ram_initiator dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_tag      (req_tag),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_tag      (rsp_tag),
    .rsp_err      (rsp_err),
    .mem_data     (mem_data),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_q        (mem_q)
  );

  assign mem_q = ram[mem_addr];

  always @(posedge clk) begin
    if (mem_we) begin
      we_cnt++;
      ram[mem_addr] <= mem_data;
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] x_rd;
    logic        x_er;
    int          x_lat;
    int          x_wr;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: RAM as a plain word array, rules applied arithmetically.
  function automatic void model(input logic we, input logic [1:0] sz,
                                input logic uns, input logic [31:0] a,
                                input logic [31:0] wd,
                                output logic [31:0] rd, output logic er,
                                output int lat, output int wr);
    int unsigned idx;
    int unsigned off;
    logic [31:0] w;
    logic [31:0] m;
    idx = a / 4;
    off = a % 4;
    er = (a >= 32'd512) || (sz == 2'd3) ||
         (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && off != 0);
`ifndef LSU_RMW_EN
    if (we && sz != 2'd2) er = 1'b1;
`endif
    rd = '0;
    lat = 1;
    wr = 0;
    if (er) return;
    w = shadow[idx];
    if (!we) begin
      if (sz == 2'd0) begin
        rd = (w >> (8 * off)) & 32'hFF;
        if (!uns && rd >= 32'h80) rd = rd + 32'hFFFFFF00;
      end else if (sz == 2'd1) begin
        rd = (w >> (8 * off)) & 32'hFFFF;
        if (!uns && rd >= 32'h8000) rd = rd + 32'hFFFF0000;
      end else begin
        rd = w;
      end
    end else if (sz == 2'd2) begin
      shadow[idx] = wd;
      wr = 1;
    end else begin
      m = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
      shadow[idx] = (w & ~m) | ((wd << (8 * off)) & m);
      wr = 1;
      lat = 3;
    end
  endfunction

  task automatic run_txn(input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] tg_in,
                         output logic [31:0] rd, output logic er,
                         output logic [3:0] tg, output int lat,
                         output int wr);
    int n;
    int w0;
    bit got;
    rd = '0;
    er = 1'b0;
    tg = '0;
    lat = -1;
    w0 = we_cnt;
    req_we = we;
    req_size = sz;
    req_unsigned = uns;
    req_addr = a;
    req_wdata = wd;
    req_tag = tg_in;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    n = 0;
    got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (req_ready) got = 1;
      else n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (got) begin
      n = 0;
      got = 0;
      while (!got && n < 10) begin
        n++;
        @(negedge clk);
        if (rsp_valid) got = 1;
        else @(posedge clk);
      end
      if (got) begin
        lat = n;
        rd = rsp_rdata;
        er = rsp_err;
        tg = rsp_tag;
      end
      @(posedge clk);
      #1;
    end
    wr = we_cnt - w0;
  endtask

  task automatic check_txn(input string nm, input logic we,
                           input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] x_rd, input logic x_er,
                           input int x_lat, input int x_wr);
    logic [31:0] rd;
    logic        er;
    logic [3:0]  tg;
    logic [3:0]  tg_in;
    int          lat;
    int          wr;
    tg_in = 4'($urandom);
    run_txn(we, sz, uns, a, wd, tg_in, rd, er, tg, lat, wr);
    chk({nm, ".rdata"}, rd, x_rd);
    chk({nm, ".err"}, 32'(er), 32'(x_er));
    chk({nm, ".tag"}, 32'(tg), 32'(tg_in));
    chk({nm, ".lat"}, lat, x_lat);
    chk({nm, ".writes"}, wr, x_wr);
  endtask

  initial begin
    logic [31:0] m_rd;
    logic        m_er;
    int          m_lat;
    int          m_wr;
    logic [31:0] exp_rd;
    logic [31:0] a;
    logic [1:0]  sz;
    logic        we;
    int          w0;
    int          r;

    for (int i = 0; i < 128; i++) begin
      ram[i] = $urandom;
      shadow[i] = ram[i];
    end
    ram[5] = 32'h8899AABB;
    shadow[5] = 32'h8899AABB;

    vt[0]  = '{1'b0, 2'd0, 1'b0, 32'h16, 32'h0, 32'hFFFFFF99, 1'b0, 1, 0};
    vt[1]  = '{1'b0, 2'd0, 1'b1, 32'h16, 32'h0, 32'h00000099, 1'b0, 1, 0};
    vt[2]  = '{1'b0, 2'd1, 1'b0, 32'h16, 32'h0, 32'hFFFF8899, 1'b0, 1, 0};
    vt[3]  = '{1'b0, 2'd1, 1'b1, 32'h14, 32'h0, 32'h0000AABB, 1'b0, 1, 0};
    vt[4]  = '{1'b0, 2'd0, 1'b0, 32'h14, 32'h0, 32'hFFFFFFBB, 1'b0, 1, 0};
`ifdef LSU_RMW_EN
    vt[5]  = '{1'b1, 2'd1, 1'b0, 32'h16, 32'h1234, 32'h0, 1'b0, 3, 1};
    vt[6]  = '{1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 32'h1234AABB, 1'b0, 1, 0};
    vt[10] = '{1'b1, 2'd0, 1'b0, 32'h10, 32'h5A, 32'h0, 1'b0, 3, 1};
`else
    vt[5]  = '{1'b1, 2'd1, 1'b0, 32'h16, 32'h1234, 32'h0, 1'b1, 1, 0};
    vt[6]  = '{1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 32'h8899AABB, 1'b0, 1, 0};
    vt[10] = '{1'b1, 2'd0, 1'b0, 32'h10, 32'h5A, 32'h0, 1'b1, 1, 0};
`endif
    vt[7]  = '{1'b1, 2'd2, 1'b0, 32'h6, 32'hCAFEF00D, 32'h0, 1'b1, 1, 0};
    vt[8]  = '{1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'h0, 1'b1, 1, 0};
    vt[9]  = '{1'b0, 2'd3, 1'b0, 32'h14, 32'h0, 32'h0, 1'b1, 1, 0};
    vt[11] = '{1'b0, 2'd1, 1'b0, 32'h15, 32'h0, 32'h0, 1'b1, 1, 0};
    vt[12] = '{1'b1, 2'd2, 1'b0, 32'h18, 32'hDEADBEEF, 32'h0, 1'b0, 1, 1};
    vt[13] = '{1'b0, 2'd0, 1'b0, 32'h1B, 32'h0, 32'hFFFFFFDE, 1'b0, 1, 0};

    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'd0;
    req_unsigned = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_tag = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.rsp_rdata", rsp_rdata, 32'd0);
    chk("reset.rsp_tag", 32'(rsp_tag), 32'd0);
    chk("reset.rsp_err", 32'(rsp_err), 32'd0);
    chk("reset.mem_we", 32'(mem_we), 32'd0);
    chk("reset.req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 14; i++) begin
      model(vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wd,
            m_rd, m_er, m_lat, m_wr);
      check_txn($sformatf("vec%0d", i), vt[i].we, vt[i].sz, vt[i].uns,
                vt[i].addr, vt[i].wd, vt[i].x_rd, vt[i].x_er,
                vt[i].x_lat, vt[i].x_wr);
    end

    // Backpressure: response held 4 cycles, then overlap with next request.
    exp_rd = shadow[5];
    req_we = 1'b0;
    req_size = 2'd2;
    req_unsigned = 1'b0;
    req_addr = 32'h14;
    req_tag = 4'hA;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    @(negedge clk);
    chk("bp.accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_addr = 32'h16;
    req_size = 2'd0;
    req_unsigned = 1'b1;
    req_tag = 4'h3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("bp.hold%0d.req_ready", k), 32'(req_ready), 32'd0);
      chk($sformatf("bp.hold%0d.rsp_valid", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp.hold%0d.rdata", k), rsp_rdata, exp_rd);
      chk($sformatf("bp.hold%0d.tag", k), 32'(rsp_tag), 32'hA);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp.overlap_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp.next.rsp_valid", 32'(rsp_valid), 32'd1);
    chk("bp.next.rdata", rsp_rdata, (shadow[5] >> 16) & 32'hFF);
    chk("bp.next.tag", 32'(rsp_tag), 32'h3);
    @(posedge clk);
    #1;

`ifdef LSU_RMW_EN
    // Reset while the byte store is in its read cycle.
    w0 = we_cnt;
    req_we = 1'b1;
    req_size = 2'd0;
    req_addr = 32'h1D;
    req_wdata = 32'hEE;
    req_tag = 4'h7;
    req_valid = 1'b1;
    @(negedge clk);
    chk("rmwrst.ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rmwrst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rmwrst.mem_we", 32'(mem_we), 32'd0);
    chk("rmwrst.idle", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rmwrst.word7", ram[7], shadow[7]);
    chk("rmwrst.writes", we_cnt - w0, 32'd0);
`endif

    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      we = 1'($urandom);
      a = {$urandom_range(0, 15), 2'b00} + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = a + 32'h200 + 32'($urandom_range(0, 4)) * 32'h400;
      r = $urandom;
      model(we, sz, 1'($urandom_range(0, 1)), a, 32'(r),
            m_rd, m_er, m_lat, m_wr);
      // Replay with the unsigned flag the model used is not needed for
      // stores; loads are re-modelled below with a fixed flag.
      if (!we) begin
        model(1'b0, sz, 1'b0, a, 32'(r), m_rd, m_er, m_lat, m_wr);
      end
      check_txn($sformatf("rnd%0d", t), we, sz, 1'b0, a, 32'(r),
                m_rd, m_er, m_lat, m_wr);
    end

    for (int i = 0; i < 16; i++) begin
      chk($sformatf("final.word%0d", i), ram[i], shadow[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
